// File: rtl/mem_queue.sv
// mem_queue: non-blocking MEM stage between EXE and WB.
// Loads complete out of band; micro-ops retire strictly in order.
module mem_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    exe_valid_i,
  output logic                    ready_o,
  input  logic [ADDR_WIDTH-1:0]   exe_out_i,
  input  logic [DATA_WIDTH-1:0]   exe_wdata_i,
  input  logic                    exe_ld_i,
  input  logic                    exe_st_i,
  input  logic [1:0]              exe_size_i,
  input  logic                    exe_unsigned_i,
  input  logic [TAG_WIDTH-1:0]    exe_tag_i,
  output logic                    valid_o,
  input  logic                    wb_ready_i,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [TAG_WIDTH-1:0]    wb_tag_o,
  output logic                    wb_misalign_o,
  output logic                    d_m_req_o,
  output logic                    d_m_we_o,
  output logic [ADDR_WIDTH-1:0]   d_m_addr_o,
  output logic [DATA_WIDTH-1:0]   d_m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] d_m_wmask_o,
  input  logic                    d_m_gnt_i,
  input  logic                    d_m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   d_m_rdata_i
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic [OFFW-1:0]       off;
    logic [1:0]            size;
    logic                  uns;
    logic                  ld;
    logic                  mis;
    logic                  done;
  } ent_t;

  ent_t           ent_q [DEPTH];
  ent_t           ent_d [DEPTH];
  logic [PW:0]    count_q, count_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW-1:0]  ld_q, ld_d;

  logic [OFFW-1:0] off;
  logic [OFFW-1:0] amask;
  logic [3:0]      nbytes;
  logic [15:0]     bmask;
  logic            mis_raw;
  logic            is_mem;
  logic            mem_op;
  logic            full;
  logic            has;
  logic            enq;
  logic            deq;
  logic            rsp;
  logic            ld_pend;
  logic [PW-1:0]   rel;
  logic [PW-1:0]   idx;
  logic            found;

  function automatic logic [DATA_WIDTH-1:0] ld_ext(
    input logic [DATA_WIDTH-1:0] rd,
    input logic [OFFW-1:0]       o,
    input logic [1:0]            sz,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] r;
    logic                  s;
    int                    lim;
    sh = rd >> {o, 3'b000};
    r  = sh;
    unique case (sz)
      2'd0: begin s = sh[7];  lim = 8;  end
      2'd1: begin s = sh[15]; lim = 16; end
      2'd2: begin s = sh[31]; lim = 32; end
      default: begin s = sh[DATA_WIDTH-1]; lim = 64; end
    endcase
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= lim) r[i] = ~uns & s;
    end
    return r;
  endfunction

  assign off     = exe_out_i[OFFW-1:0];
  assign nbytes  = 4'd1 << exe_size_i;
  assign amask   = OFFW'(nbytes - 4'd1);
  assign bmask   = (16'd1 << nbytes) - 16'd1;
  assign mis_raw = |(off & amask);
  assign is_mem  = exe_ld_i | exe_st_i;
  assign mem_op  = is_mem & ~mis_raw;
  assign full    = count_q == CNT_FULL;
  assign has     = count_q != '0;

  assign ready_o   = ~full & ~rst_i & (~mem_op | d_m_gnt_i);
  assign enq       = exe_valid_i & ready_o;
  assign d_m_req_o = exe_valid_i & mem_op & ~full & ~rst_i;
  assign d_m_we_o  = exe_st_i;
  assign d_m_addr_o =
    {exe_out_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign d_m_wdata_o = exe_wdata_i << {off, 3'b000};
  assign d_m_wmask_o =
    exe_st_i ? (NB'(bmask) << off) : '0;

  assign valid_o       = has & ent_q[head_q].done;
  assign deq           = valid_o & wb_ready_i;
  assign wb_data_o     = has ? ent_q[head_q].data : '0;
  assign wb_tag_o      = has ? ent_q[head_q].tag : '0;
  assign wb_misalign_o = has & ent_q[head_q].mis;

  // ld_q is only meaningful while it lies inside the live window
  assign rel     = ld_q - head_q;
  assign ld_pend = ({1'b0, rel} < count_q) &
                   ent_q[ld_q].ld & ~ent_q[ld_q].done;
  assign rsp     = d_m_rvalid_i & ld_pend;

  always_comb begin
    ent_d   = ent_q;
    head_d  = deq ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    idx     = '0;
    found   = 1'b0;
    if (enq & ~deq) count_d = count_q + (PW+1)'(1);
    if (~enq & deq) count_d = count_q - (PW+1)'(1);
    if (rsp) begin
      ent_d[ld_q].data = ld_ext(d_m_rdata_i, ent_q[ld_q].off,
                                ent_q[ld_q].size, ent_q[ld_q].uns);
      ent_d[ld_q].done = 1'b1;
    end
    if (enq) begin
      ent_d[tail_q].tag  = exe_tag_i;
      ent_d[tail_q].data = is_mem ? '0 : DATA_WIDTH'(exe_out_i);
      ent_d[tail_q].off  = off;
      ent_d[tail_q].size = exe_size_i;
      ent_d[tail_q].uns  = exe_unsigned_i;
      ent_d[tail_q].ld   = exe_ld_i & ~mis_raw;
      ent_d[tail_q].mis  = is_mem & mis_raw;
      ent_d[tail_q].done = ~(exe_ld_i & ~mis_raw);
    end
    // oldest outstanding load, or tail when none is waiting
    ld_d = tail_d;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_d + PW'(k);
      if (!found && ((PW+1)'(k) < count_d) &&
          ent_d[idx].ld && !ent_d[idx].done) begin
        ld_d  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].done <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ld_q    <= ld_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_queue.sv
// tb_mem_queue: directed scenarios plus a randomized run
// checked against an in-order queue model of mem_queue.
module tb_mem_queue;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 4;
  localparam int TW  = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          exe_valid_i;
  logic          ready_o;
  logic [AW-1:0] exe_out_i;
  logic [DW-1:0] exe_wdata_i;
  logic          exe_ld_i;
  logic          exe_st_i;
  logic [1:0]    exe_size_i;
  logic          exe_unsigned_i;
  logic [TW-1:0] exe_tag_i;
  logic          valid_o;
  logic          wb_ready_i;
  logic [DW-1:0] wb_data_o;
  logic [TW-1:0] wb_tag_o;
  logic          wb_misalign_o;
  logic          d_m_req_o;
  logic          d_m_we_o;
  logic [AW-1:0] d_m_addr_o;
  logic [DW-1:0] d_m_wdata_o;
  logic [DW/8-1:0] d_m_wmask_o;
  logic          d_m_gnt_i;
  logic          d_m_rvalid_i;
  logic [DW-1:0] d_m_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mem_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEPTH(DEP), .TAG_WIDTH(TW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exe_valid_i(exe_valid_i), .ready_o(ready_o),
    .exe_out_i(exe_out_i), .exe_wdata_i(exe_wdata_i),
    .exe_ld_i(exe_ld_i), .exe_st_i(exe_st_i),
    .exe_size_i(exe_size_i), .exe_unsigned_i(exe_unsigned_i),
    .exe_tag_i(exe_tag_i), .valid_o(valid_o),
    .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_tag_o(wb_tag_o), .wb_misalign_o(wb_misalign_o),
    .d_m_req_o(d_m_req_o), .d_m_we_o(d_m_we_o),
    .d_m_addr_o(d_m_addr_o), .d_m_wdata_o(d_m_wdata_o),
    .d_m_wmask_o(d_m_wmask_o), .d_m_gnt_i(d_m_gnt_i),
    .d_m_rvalid_i(d_m_rvalid_i), .d_m_rdata_i(d_m_rdata_i)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] data;
    int          off;
    int          sz;
    bit          un;
    bit          mis;
    bit          ld;
    bit          st;
    bit          done;
  } m_t;

  function automatic logic [31:0] m_ext(
    input logic [31:0] rd, input int off,
    input int sz, input bit un
  );
    longint unsigned v;
    int bits;
    bits = 8 << sz;
    v = (longint'(rd) >> (8 * off)) & ((64'd1 << bits) - 1);
    if (!un && (((v >> (bits - 1)) & 1) != 0))
      v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic idle_in();
    exe_valid_i = 0; exe_out_i = 0; exe_wdata_i = 0;
    exe_ld_i = 0; exe_st_i = 0; exe_size_i = 0;
    exe_unsigned_i = 0; exe_tag_i = 0;
    d_m_gnt_i = 0; d_m_rvalid_i = 0; d_m_rdata_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1; exe_valid_i = 1; exe_ld_i = 1;
    exe_out_i = 32'h100; exe_size_i = 2; d_m_gnt_i = 1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL rst_ready got=%0b want=0", ready_o);
    end
    checks++;
    if (d_m_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_req got=%0b want=0", d_m_req_o);
    end
    @(negedge clk_i);
    idle_in(); rst_i = 0; #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%0b want=0", valid_o);
    end
    checks++;
    if (wb_data_o !== 32'h0 || wb_tag_o !== 8'h0) begin
      errors++;
      $display("FAIL rst_wb got=%h/%h want=0/0", wb_data_o, wb_tag_o);
    end
    checks++;
    if (wb_misalign_o !== 1'b0) begin
      errors++; $display("FAIL rst_mis got=%0b want=0", wb_misalign_o);
    end
    checks++;
    if (dut.count_q !== '0) begin
      errors++; $display("FAIL rst_count got=%0d want=0", dut.count_q);
    end
  endtask

  task automatic test_load_sext();
    @(negedge clk_i);
    exe_valid_i = 1; exe_ld_i = 1; exe_out_i = 32'h1003;
    exe_size_i = 0; exe_unsigned_i = 0; exe_tag_i = 8'h11;
    d_m_gnt_i = 1; #1;
    checks++;
    if (d_m_req_o !== 1'b1 || d_m_we_o !== 1'b0) begin
      errors++;
      $display("FAIL lb_req got=%0b/%0b want=1/0", d_m_req_o, d_m_we_o);
    end
    checks++;
    if (d_m_addr_o !== 32'h1000 || d_m_wmask_o !== 4'h0) begin
      errors++;
      $display("FAIL lb_addr got=%h/%h want=1000/0",
               d_m_addr_o, d_m_wmask_o);
    end
    @(negedge clk_i); idle_in();
    @(negedge clk_i);
    @(negedge clk_i);
    d_m_rvalid_i = 1; d_m_rdata_i = 32'h8000_0000; #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL lb_early got=%0b want=0", valid_o);
    end
    @(negedge clk_i); idle_in(); #1;
    checks++;
    if (valid_o !== 1'b1 || wb_data_o !== 32'hFFFF_FF80 ||
        wb_tag_o !== 8'h11) begin
      errors++;
      $display("FAIL lb_data got=%0b/%h/%h want=1/ffffff80/11",
               valid_o, wb_data_o, wb_tag_o);
    end
    wb_ready_i = 1;
    @(negedge clk_i); wb_ready_i = 0; #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL lb_retire got=%0b want=0", valid_o);
    end
  endtask

  task automatic test_store_half();
    @(negedge clk_i);
    exe_valid_i = 1; exe_st_i = 1; exe_out_i = 32'h2002;
    exe_wdata_i = 32'hABCD; exe_size_i = 1;
    exe_tag_i = 8'h22; d_m_gnt_i = 1; #1;
    checks++;
    if (d_m_wmask_o !== 4'b1100 || d_m_wdata_o !== 32'hABCD_0000) begin
      errors++;
      $display("FAIL sh_lanes got=%b/%h want=1100/abcd0000",
               d_m_wmask_o, d_m_wdata_o);
    end
    checks++;
    if (d_m_we_o !== 1'b1 || d_m_req_o !== 1'b1) begin
      errors++;
      $display("FAIL sh_req got=%0b/%0b want=1/1", d_m_we_o, d_m_req_o);
    end
    @(negedge clk_i); idle_in(); #1;
    checks++;
    if (valid_o !== 1'b1 || wb_tag_o !== 8'h22 ||
        wb_misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL sh_valid got=%0b/%h/%0b want=1/22/0",
               valid_o, wb_tag_o, wb_misalign_o);
    end
    wb_ready_i = 1;
    @(negedge clk_i); wb_ready_i = 0;
  endtask

  task automatic test_misalign();
    @(negedge clk_i);
    exe_valid_i = 1; exe_ld_i = 1; exe_out_i = 32'h3001;
    exe_size_i = 2; exe_tag_i = 8'h33; d_m_gnt_i = 0; #1;
    checks++;
    if (d_m_req_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mis_req got=%0b/%0b want=0/1", d_m_req_o, ready_o);
    end
    @(negedge clk_i); idle_in(); #1;
    checks++;
    if (valid_o !== 1'b1 || wb_misalign_o !== 1'b1 ||
        wb_data_o !== 32'h0 || wb_tag_o !== 8'h33) begin
      errors++;
      $display("FAIL mis_wb got=%0b/%0b/%h/%h want=1/1/0/33",
               valid_o, wb_misalign_o, wb_data_o, wb_tag_o);
    end
    wb_ready_i = 1;
    @(negedge clk_i); wb_ready_i = 0;
  endtask

  task automatic test_fill_order();
    logic [31:0] d [4];
    logic [7:0]  et [4];
    logic [31:0] ed [4];
    d[0] = 32'h1111_0001; d[1] = 32'h2222_0002;
    d[2] = 32'h3333_0003; d[3] = 32'h4444_0004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      exe_valid_i = 1; exe_ld_i = 1; exe_size_i = 2;
      exe_out_i = 32'h100 + 32'(4 * i);
      exe_tag_i = 8'(i + 1); d_m_gnt_i = 1; #1;
      checks++;
      if (ready_o !== 1'b1) begin
        errors++; $display("FAIL fill_acc%0d got=%0b want=1", i, ready_o);
      end
    end
    @(negedge clk_i);
    exe_ld_i = 0; exe_out_i = 32'h55AA; exe_tag_i = 8'h5;
    d_m_gnt_i = 0; d_m_rvalid_i = 1; d_m_rdata_i = d[0]; #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL fill_full got=%0b want=0", ready_o);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk_i); d_m_rdata_i = d[k]; #1;
      checks++;
      if (ready_o !== 1'b0) begin
        errors++; $display("FAIL fill_hold%0d got=%0b want=0", k, ready_o);
      end
    end
    @(negedge clk_i);
    d_m_rvalid_i = 0; wb_ready_i = 1; #1;
    checks++;
    if (valid_o !== 1'b1 || wb_tag_o !== 8'h1 ||
        wb_data_o !== d[0] || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_first got=%0b/%h/%h/%0b want=1/01/%h/0",
               valid_o, wb_tag_o, wb_data_o, ready_o, d[0]);
    end
    et[0] = 8'h2; et[1] = 8'h3; et[2] = 8'h4; et[3] = 8'h5;
    ed[0] = d[1]; ed[1] = d[2]; ed[2] = d[3]; ed[3] = 32'h55AA;
    @(negedge clk_i); #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL fill_reopen got=%0b want=1", ready_o);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk_i); exe_valid_i = 0; #1;
      end
      checks++;
      if (valid_o !== 1'b1 || wb_tag_o !== et[k] ||
          wb_data_o !== ed[k]) begin
        errors++;
        $display("FAIL fill_ret%0d got=%0b/%h/%h want=1/%h/%h",
                 k, valid_o, wb_tag_o, wb_data_o, et[k], ed[k]);
      end
    end
    @(negedge clk_i); #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL fill_empty got=%0b want=0", valid_o);
    end
    idle_in(); wb_ready_i = 0;
  endtask

  task automatic test_mixed_order();
    wb_ready_i = 1;
    @(negedge clk_i);
    exe_valid_i = 1; exe_ld_i = 1; exe_out_i = 32'h40;
    exe_size_i = 2; exe_tag_i = 8'hA; d_m_gnt_i = 1;
    @(negedge clk_i);
    exe_ld_i = 0; exe_out_i = 32'h1234; exe_tag_i = 8'hB;
    d_m_gnt_i = 0; #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL mix_accb got=%0b want=1", ready_o);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); idle_in();
      if (k == 3) begin
        d_m_rvalid_i = 1; d_m_rdata_i = 32'hDEAD_BEEF;
      end
      #1;
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL mix_hold%0d got=%0b want=0", k, valid_o);
      end
    end
    @(negedge clk_i); idle_in(); #1;
    checks++;
    if (valid_o !== 1'b1 || wb_tag_o !== 8'hA ||
        wb_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mix_a got=%0b/%h/%h want=1/0a/deadbeef",
               valid_o, wb_tag_o, wb_data_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (valid_o !== 1'b1 || wb_tag_o !== 8'hB ||
        wb_data_o !== 32'h1234) begin
      errors++;
      $display("FAIL mix_b got=%0b/%h/%h want=1/0b/00001234",
               valid_o, wb_tag_o, wb_data_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL mix_empty got=%0b want=0", valid_o);
    end
    wb_ready_i = 0;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      exe_valid_i = 1; exe_ld_i = 1; exe_size_i = 2;
      exe_out_i = 32'h200 + 32'(4 * i);
      exe_tag_i = 8'(8'h31 + i); d_m_gnt_i = 1;
    end
    @(negedge clk_i); idle_in(); rst_i = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      rst_i = 0; d_m_rvalid_i = 1; d_m_rdata_i = 32'h77; #1;
      checks++;
      if (valid_o !== 1'b0 || dut.count_q !== '0) begin
        errors++;
        $display("FAIL rmid_drop%0d got=%0b/%0d want=0/0",
                 k, valid_o, dut.count_q);
      end
    end
    @(negedge clk_i);
    idle_in(); exe_valid_i = 1; exe_ld_i = 1; exe_size_i = 2;
    exe_out_i = 32'h300; exe_tag_i = 8'h33; d_m_gnt_i = 1;
    @(negedge clk_i); idle_in(); #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL rmid_stale got=%0b want=0", valid_o);
    end
    @(negedge clk_i);
    d_m_rvalid_i = 1; d_m_rdata_i = 32'h1234_5678;
    @(negedge clk_i); idle_in(); #1;
    checks++;
    if (valid_o !== 1'b1 || wb_data_o !== 32'h1234_5678 ||
        wb_tag_o !== 8'h33) begin
      errors++;
      $display("FAIL rmid_new got=%0b/%h/%h want=1/12345678/33",
               valid_o, wb_data_o, wb_tag_o);
    end
    wb_ready_i = 1;
    @(negedge clk_i); wb_ready_i = 0;
  endtask

  task automatic test_random();
    m_t mq[$];
    logic [31:0] rq[$];
    m_t e;
    bit v, un, gnt, wbr, rv, mis, memop, full, mrdy, ev;
    int kind, sz, bytes, off;
    logic [31:0] addr, wd, rd, wm;
    logic [7:0] tag;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk_i);
      v = $urandom_range(0, 3) != 0;
      kind = $urandom_range(0, 2);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      sz = $urandom_range(0, 2);
      un = 1'($urandom_range(0, 1));
      tag = 8'($urandom);
      wd = $urandom;
      gnt = $urandom_range(0, 3) != 0;
      wbr = $urandom_range(0, 2) != 0;
      rv = rq.size() > 0 && $urandom_range(0, 1) == 1;
      exe_valid_i = v; exe_out_i = addr; exe_wdata_i = wd;
      exe_ld_i = kind == 1; exe_st_i = kind == 2;
      exe_size_i = 2'(sz); exe_unsigned_i = un; exe_tag_i = tag;
      d_m_gnt_i = gnt; wb_ready_i = wbr; d_m_rvalid_i = rv;
      d_m_rdata_i = rv ? rq[0] : $urandom;
      #1;
      bytes = 1 << sz;
      off = int'(addr[1:0]);
      mis = kind != 0 && (off % bytes) != 0;
      memop = kind != 0 && !mis;
      full = mq.size() == DEP;
      mrdy = !full && (!memop || gnt);
      ev = mq.size() > 0 && mq[0].done;
      checks++;
      if (ready_o !== mrdy) begin
        errors++;
        $display("FAIL rnd_ready c%0d got=%0b want=%0b", cyc, ready_o, mrdy);
      end
      checks++;
      if (d_m_req_o !== (v && memop && !full)) begin
        errors++;
        $display("FAIL rnd_req c%0d got=%0b want=%0b",
                 cyc, d_m_req_o, v && memop && !full);
      end
      checks++;
      if (valid_o !== ev) begin
        errors++;
        $display("FAIL rnd_valid c%0d got=%0b want=%0b", cyc, valid_o, ev);
      end
      if (ev) begin
        checks++;
        if (wb_tag_o !== mq[0].tag || wb_misalign_o !== mq[0].mis ||
            (!mq[0].st && wb_data_o !== mq[0].data)) begin
          errors++;
          $display("FAIL rnd_wb c%0d got=%h/%0b/%h want=%h/%0b/%h",
                   cyc, wb_tag_o, wb_misalign_o, wb_data_o,
                   mq[0].tag, mq[0].mis, mq[0].data);
        end
      end
      if (v && memop && !full) begin
        checks++;
        if (d_m_addr_o !== (addr & 32'hFFFF_FFFC)) begin
          errors++;
          $display("FAIL rnd_addr c%0d got=%h want=%h",
                   cyc, d_m_addr_o, addr & 32'hFFFF_FFFC);
        end
        if (kind == 2) begin
          wm = ((32'd1 << bytes) - 1) << off;
          checks++;
          if (d_m_wmask_o !== wm[3:0] ||
              d_m_wdata_o !== (wd << (8 * off))) begin
            errors++;
            $display("FAIL rnd_st c%0d got=%b/%h want=%b/%h", cyc,
                     d_m_wmask_o, d_m_wdata_o, wm[3:0], wd << (8 * off));
          end
        end
      end
      @(posedge clk_i);
      if (ev && wbr) void'(mq.pop_front());
      if (rv) begin
        rd = rq.pop_front();
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].ld && !mq[i].done) begin
            mq[i].data = m_ext(rd, mq[i].off, mq[i].sz, mq[i].un);
            mq[i].done = 1;
            break;
          end
        end
      end
      if (v && mrdy) begin
        e.tag = tag; e.off = off; e.sz = sz; e.un = un;
        e.mis = mis; e.ld = kind == 1 && !mis;
        e.st = kind == 2 && !mis; e.done = !e.ld;
        e.data = kind == 0 ? addr : 32'h0;
        mq.push_back(e);
        if (e.ld) rq.push_back($urandom);
      end
    end
    @(negedge clk_i); idle_in(); wb_ready_i = 0;
  endtask

  initial begin
    rst_i = 1; wb_ready_i = 0;
    idle_in();
    test_reset();
    test_load_sext();
    test_store_half();
    test_misalign();
    test_fill_order();
    test_mixed_order();
    test_reset_midflight();
    @(negedge clk_i); rst_i = 1;
    @(negedge clk_i); rst_i = 0;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
